rr_arb8: RTL and testbench



---
 rtl/rr_arb8.sv | 123 ++++++++++++
 tb/tb_rr_arb8.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb8.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb8
// Brief   : 8-way round-robin arbiter, registered one-hot + binary grant,
//           release on request drop, hold-time preemption.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb8 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       preempt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_hold_last = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic             c_preempt_en = (MAX_HOLD != 0);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_ptr, w_ptr_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_grant, w_grant_nxt;
  logic [CNT_W-1:0] r_hold, w_hold_nxt;
  logic             r_preempt, w_preempt_nxt;

  logic [15:0]      w_req2;
  logic [7:0]       w_rot;
  logic [2:0]       w_off;
  logic [2:0]       w_sel;
  logic             w_others;
  logic             w_hold_hit;

  // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
  assign w_req2 = {req, req};
  assign w_rot  = 8'(w_req2 >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
  end

  assign w_sel      = r_ptr + w_off;
  assign w_others   = |(req & ~r_grant);
  assign w_hold_hit = c_preempt_en && (r_hold == c_hold_last);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
    w_grant_nxt   = r_grant;
    w_hold_nxt    = r_hold;
    w_preempt_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && (|req)) begin
          w_state_nxt = GRANT;
          w_grant_nxt = 8'b1 << w_sel;
          w_idx_nxt   = w_sel;
          w_hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end else if (!req[r_idx]) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = r_idx + 3'd1;
        end else if (w_hold_hit && w_others) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_ptr_nxt     = r_idx + 3'd1;
          w_preempt_nxt = 1'b1;
        end else if (r_hold != c_hold_last) begin
          w_hold_nxt = r_hold + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_grant   <= '0;
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_idx     <= w_idx_nxt;
      r_grant   <= w_grant_nxt;
      r_hold    <= w_hold_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_idx;
  assign grant_valid = |r_grant;
  assign preempt     = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_arb8
// Brief   : Self-checking bench for rr_arb8 against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rr_arb8;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  int n_chk;
  int n_err;

  rr_arb8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: who holds the resource, for how many cycles, and where the
  // next search starts.
  int         m_holder;
  int         m_ptr;
  int         m_held;
  logic [2:0] m_idx;
  logic       m_preempt;

  initial begin
    int c;
    m_holder  = -1;
    m_ptr     = 0;
    m_held    = 0;
    m_idx     = 3'd0;
    m_preempt = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_holder  = -1;
        m_ptr     = 0;
        m_held    = 0;
        m_idx     = 3'd0;
        m_preempt = 1'b0;
      end else begin
        m_preempt = 1'b0;
        if (m_holder < 0) begin
          if (en && req != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
              c = (m_ptr + k) % 8;
              if (req[c] && m_holder < 0) m_holder = c;
            end
            m_held = 1;
            m_idx  = 3'(m_holder);
          end
        end else if (!en) begin
          m_holder = -1;
        end else if (!req[m_holder]) begin
          m_ptr    = (m_holder + 1) % 8;
          m_holder = -1;
        end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD &&
                     (req & ~(8'd1 << m_holder)) != 8'h00) begin
          m_preempt = 1'b1;
          m_ptr     = (m_holder + 1) % 8;
          m_holder  = -1;
        end else begin
          m_held++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_grant", grant, (m_holder < 0) ? 32'h0 : (32'h1 << m_holder));
        chk("m_idx", grant_idx, m_idx);
        chk("m_valid", grant_valid, m_holder >= 0);
        chk("m_preempt", preempt, m_preempt);
        chk("onehot0", $onehot0(grant), 1);
      end
    end
  end

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!grant_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, grant_valid, 1);
  endtask

  initial begin
    int hcnt;
    int prev;
    int run;
    int first;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;

    // Reset then single request
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_idx", grant_idx, 0);
    chk("rst_valid", grant_valid, 0);
    chk("rst_preempt", preempt, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 8'h10;
    @(negedge clk);
    chk("single_grant", grant, 8'h10);
    chk("single_idx", grant_idx, 4);
    req = 8'h00;
    @(negedge clk);
    chk("single_release", grant, 0);
    chk("single_hold_idx", grant_idx, 4);

    // Fairness: all request, each holder drops after two cycles; ptr starts at 5
    req  = 8'hFF;
    hcnt = 0;
    prev = -1;
    repeat (60) begin
      @(negedge clk);
      if (grant_valid) begin
        hcnt++;
        if (hcnt == 1) begin
          if (prev >= 0) chk("rr_order", grant_idx, (prev + 1) % 8);
          else           chk("rr_first", grant_idx, 5);
          prev = grant_idx;
        end
        if (hcnt == 2) req = 8'hFF & ~grant;
      end else begin
        hcnt = 0;
        req  = 8'hFF;
      end
    end

    // Wrap-around after idx 7 released
    req = 8'h00;
    repeat (2) @(negedge clk);
    req = 8'h80;
    wait_grant("wrap7");
    chk("wrap7_idx", grant_idx, 7);
    req = 8'h00;
    @(negedge clk);
    req = 8'h81;
    @(negedge clk);
    chk("wrap0_idx", grant_idx, 0);
    chk("wrap0_valid", grant_valid, 1);

    // Preemption between two requesters (ptr is 1 after releasing idx 0)
    req = 8'h00;
    repeat (2) @(negedge clk);
    req = 8'h03;
    wait_grant("pre");
    first = grant_idx;
    chk("pre_first", first, 1);
    run = 0;
    while (grant_valid && run < 30) begin
      run++;
      @(negedge clk);
    end
    chk("pre_run", run, MAX_HOLD);
    chk("pre_pulse", preempt, 1);
    @(negedge clk);
    chk("pre_pulse_len", preempt, 0);
    chk("pre_next", grant_idx, 0);
    repeat (12) @(negedge clk);

    // Lone holder never preempted
    req = 8'h00;
    repeat (2) @(negedge clk);
    req = 8'h04;
    wait_grant("lone");
    repeat (20) begin
      @(negedge clk);
      chk("lone_grant", grant, 8'h04);
      chk("lone_preempt", preempt, 0);
    end

    // Enable drop mid-grant
    req = 8'h08;
    wait_grant("en");
    chk("en_idx", grant_idx, 3);
    en = 1'b0;
    @(negedge clk);
    chk("en_off", grant, 0);
    repeat (2) @(negedge clk);
    chk("en_off_hold", grant, 0);
    en = 1'b1;
    wait_grant("en_back");
    chk("en_back_idx", grant_idx, 3);

    // Async reset mid-grant
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_idx", grant_idx, 0);
    chk("arst_valid", grant_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'hFF;
    @(negedge clk);
    chk("arst_regrant", grant_idx, 0);
    chk("arst_regrant_v", grant_valid, 1);

    // Randomized traffic
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) req = 8'($urandom() & $urandom());
      if ($urandom_range(15) == 0) req = 8'h00;
      en = ($urandom_range(31) != 0);
      if ($urandom_range(299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
